// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide: shift-add MUL/MULH and restoring DIVU/REMU.
// Each operation retires one result bit per clock and takes W cycles.
module mul_div_unit #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         Start,
  input  logic [1:0]   Op,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         Busy,
  output logic         Done,
  output logic [W-1:0] Result,
  output logic         DivByZero
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   opnd_q, opnd_d;    // multiplicand (MUL/MULH) or divisor (DIVU/REMU)
  logic [W-1:0]   hi_q, hi_d;        // product high half or partial remainder
  logic [W-1:0]   lo_q, lo_d;        // multiplier/product low half or dividend/quotient
  logic [W-1:0]   result_q, result_d;
  logic           dbz_q, dbz_d;

  logic [W:0]     sum;
  logic [W:0]     shifted;
  logic [W-1:0]   diff;
  logic           ge;
  logic [W-1:0]   step_hi, step_lo;

  // State register plus datapath flops.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_RUN;
      S_RUN:   if (cnt_q == CW'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One iteration of either algorithm, computed from the current registers.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {hi_q, lo_q[W-1]};
    ge      = (shifted >= {1'b0, opnd_q});
    // When ge holds the true difference is below 2^W, so W bits suffice.
    diff    = shifted[W-1:0] - opnd_q;
    if (op_q[1]) begin
      step_hi = ge ? diff : shifted[W-1:0];
      step_lo = {lo_q[W-2:0], ge};
    end else begin
      step_hi = sum[W:1];
      step_lo = {sum[0], lo_q[W-1:1]};
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          op_d   = Op;
          opnd_d = Op[1] ? B : A;
          lo_d   = Op[1] ? A : B;
          hi_d   = '0;
          cnt_d  = CW'(W);
        end
      end
      S_RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CW'(1);
        // Op[0] picks the high register: MULH's upper half or REMU's remainder.
        if (cnt_q == CW'(1)) begin
          result_d = op_q[0] ? step_hi : step_lo;
          dbz_d    = op_q[1] && (opnd_q == '0);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    Busy = (state_q == S_RUN);
    Done = (state_q == S_DONE);
  end

  assign Result    = result_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit (W=32): table of operations plus
// hand sequences for Start-during-RUN and reset-during-RUN.
module tb_mul_div_unit;

  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          Start;
  logic [1:0]    Op;
  logic [W-1:0]  A, B;
  logic          Busy, Done, DivByZero;
  logic [W-1:0]  Result;

  int checks = 0;
  int failures = 0;

  mul_div_unit #(.W(W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Result(Result), .DivByZero(DivByZero)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] res;
    logic         dbz;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        input logic [W-1:0] er, input logic edbz, input string tag);
    int n;
    bit got;
    bit busy_ok;
    @(negedge CLK);
    A = a; B = b; Op = op; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    chk({tag, " busy_after_start"}, {31'd0, Busy}, 32'd1);
    n = 0; got = 0; busy_ok = 1;
    while (!got && n < 100) begin
      @(posedge CLK); #1;
      n++;
      if (Done) got = 1;
      else if (!Busy) busy_ok = 0;
    end
    chk({tag, " latency"}, n, W);
    chk({tag, " busy_held"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, " result"}, Result, er);
    chk({tag, " divbyzero"}, {31'd0, DivByZero}, {31'd0, edbz});
    chk({tag, " busy_at_done"}, {31'd0, Busy}, 32'd0);
    @(posedge CLK); #1;
    chk({tag, " done_pulse_len"}, {31'd0, Done}, 32'd0);
    chk({tag, " result_held"}, Result, er);
    $display("op=%0d A=0x%h B=0x%h -> Result=0x%h DivByZero=%0b cycles=%0d", op, a, b, Result, DivByZero, n);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    int first_done;
    logic [W-1:0] res_at_done;

    vecs[0]  = '{32'd7,        32'd6,        2'b00, 32'd42,       1'b0};
    vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h00000001, 1'b0};
    vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'hFFFFFFFE, 1'b0};
    vecs[3]  = '{32'd100,      32'd7,        2'b10, 32'd14,       1'b0};
    vecs[4]  = '{32'd100,      32'd7,        2'b11, 32'd2,        1'b0};
    vecs[5]  = '{32'd5,        32'd0,        2'b10, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{32'd5,        32'd0,        2'b11, 32'd5,        1'b1};
    vecs[7]  = '{32'd0,        32'd1234,     2'b00, 32'd0,        1'b0};
    vecs[8]  = '{32'd1234,     32'd0,        2'b01, 32'd0,        1'b0};
    vecs[9]  = '{32'h12345678, 32'h10,       2'b00, 32'h23456780, 1'b0};
    vecs[10] = '{32'h12345678, 32'h10,       2'b01, 32'h00000001, 1'b0};
    vecs[11] = '{32'd3,        32'd10,       2'b10, 32'd0,        1'b0};
    vecs[12] = '{32'd3,        32'd10,       2'b11, 32'd3,        1'b0};
    vecs[13] = '{32'hFFFFFFFF, 32'd1,        2'b10, 32'hFFFFFFFF, 1'b0};
    vecs[14] = '{32'hFFFFFFFF, 32'd1,        2'b11, 32'd0,        1'b0};
    vecs[15] = '{32'h80000000, 32'd2,        2'b00, 32'd0,        1'b0};
    vecs[16] = '{32'h80000000, 32'd2,        2'b01, 32'd1,        1'b0};
    vecs[17] = '{32'hDEADBEEF, 32'h10,       2'b10, 32'h0DEADBEE, 1'b0};
    vecs[18] = '{32'hDEADBEEF, 32'h10,       2'b11, 32'hF,        1'b0};
    vecs[19] = '{32'h00010000, 32'h00010000, 2'b00, 32'd0,        1'b0};
    vecs[20] = '{32'h00010000, 32'h00010000, 2'b01, 32'd1,        1'b0};
    vecs[21] = '{32'd0,        32'd0,        2'b11, 32'd0,        1'b1};
    vecs[22] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'd1,        1'b0};
    vecs[23] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 2'b11, 32'hFFFFFFFE, 1'b0};

    RESET_N = 1'b0; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
    repeat (2) @(negedge CLK);
    chk("reset busy", {31'd0, Busy}, 32'd0);
    chk("reset done", {31'd0, Done}, 32'd0);
    chk("reset result", Result, 32'd0);
    chk("reset divbyzero", {31'd0, DivByZero}, 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("idle no start busy", {31'd0, Busy}, 32'd0);

    for (int i = 0; i < 24; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].dbz, $sformatf("vec%0d", i));

    // Start re-pulsed and operands changed while RUN: must be ignored.
    @(negedge CLK);
    A = 32'd100; B = 32'd7; Op = 2'b10; Start = 1'b1;
    @(posedge CLK); #1;
    dones = 0; first_done = 0; res_at_done = '0;
    for (int c = 1; c <= 80; c++) begin
      if (c <= 20) begin
        Start = 1'b1; A = 32'd9; B = 32'd3; Op = 2'b00;
      end else begin
        Start = 1'b0;
      end
      @(posedge CLK); #1;
      if (Done) begin
        dones++;
        if (first_done == 0) begin
          first_done = c;
          res_at_done = Result;
        end
      end
    end
    chk("ignore_start done_count", dones, 32'd1);
    chk("ignore_start latency", first_done, W);
    chk("ignore_start result", res_at_done, 32'd14);
    $display("ignore-start sequence: dones=%0d first=%0d Result=0x%h", dones, first_done, res_at_done);

    // Asynchronous reset in the middle of a DIVU.
    @(negedge CLK);
    A = 32'd1000; B = 32'd3; Op = 2'b10; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    chk("midreset busy_before", {31'd0, Busy}, 32'd1);
    RESET_N = 1'b0;
    #1;
    chk("midreset busy", {31'd0, Busy}, 32'd0);
    chk("midreset result", Result, 32'd0);
    chk("midreset divbyzero", {31'd0, DivByZero}, 32'd0);
    chk("midreset done", {31'd0, Done}, 32'd0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    dones = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge CLK); #1;
      if (Done || Busy) dones++;
    end
    chk("midreset no_activity", dones, 32'd0);
    $display("mid-op reset sequence: post-reset activity cycles=%0d Result=0x%h", dones, Result);
    run_op(32'd5, 32'd0, 2'b11, 32'd5, 1'b1, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
